// File: rtl/pong_core.sv
// Pong game core: ball motion, paddle/wall reflection, scoring and match sequencing.
// Advances only on frame_tick; everything else is a plain clocked state machine.
module pong_core #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_X     = 16,
  parameter int SPEED        = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_MAX    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [19:0] ppos,
  output logic [19:0] ball,
  output logic [7:0]  score,
  output logic [1:0]  state,
  output logic        point_p1,
  output logic        point_p2,
  output logic        game_over
);
  localparam int CX   = (H_RES - BALL_SIZE) / 2;
  localparam int CY   = (V_RES - BALL_SIZE) / 2;
  localparam int LF   = PADDLE_X + PADDLE_W;
  localparam int RF   = H_RES - PADDLE_X - PADDLE_W;
  localparam int HOLD = SERVE_FRAMES / 2;
  localparam int CW   = $clog2(SERVE_FRAMES + 1);

  localparam logic signed [10:0] SPEED_S = 11'(SPEED);
  localparam logic signed [10:0] BS_S    = 11'(BALL_SIZE);
  localparam logic signed [10:0] LF_S    = 11'(LF);
  localparam logic signed [10:0] RF_S    = 11'(RF);
  localparam logic signed [10:0] XMAX_S  = 11'(H_RES - BALL_SIZE);
  localparam logic signed [10:0] YMAX_S  = 11'(V_RES - BALL_SIZE);

  typedef enum logic [1:0] {
    SERVE    = 2'd0,
    PLAY     = 2'd1,
    POINT    = 2'd2,
    GAMEOVER = 2'd3
  } state_t;

  state_t        st;
  logic [9:0]    bx, by;
  logic          dx, dy, serve_dy;   // 1 means moving toward +x / +y
  logic [CW-1:0] cnt;
  logic [3:0]    s1, s2;

  logic signed [10:0] x_s, y_s, nx, ny;
  logic [11:0]        by_w, p1_w, p2_w;
  logic               ov1, ov2;
  logic               wall_t, wall_b, hit_l, hit_r, miss_l, miss_r;

  assign x_s = {1'b0, bx};
  assign y_s = {1'b0, by};
  assign nx  = dx ? x_s + SPEED_S : x_s - SPEED_S;
  assign ny  = dy ? y_s + SPEED_S : y_s - SPEED_S;

  // 12-bit overlap math so a paddle parked near 1023 cannot wrap into range.
  assign by_w = {2'b00, by};
  assign p1_w = {2'b00, ppos[9:0]};
  assign p2_w = {2'b00, ppos[19:10]};
  assign ov1  = (by_w + 12'(BALL_SIZE) > p1_w) && (by_w < p1_w + 12'(PADDLE_H));
  assign ov2  = (by_w + 12'(BALL_SIZE) > p2_w) && (by_w < p2_w + 12'(PADDLE_H));

  assign wall_t = (ny <= 11'sd0);
  assign wall_b = (ny >= YMAX_S);
  assign hit_l  = !dx && (x_s >= LF_S) && (nx <= LF_S) && ov1;
  assign hit_r  = dx && (x_s + BS_S <= RF_S) && (nx + BS_S >= RF_S) && ov2;
  assign miss_l = (nx <= 11'sd0);
  assign miss_r = (nx >= XMAX_S);

  always_ff @(posedge clk) begin
    point_p1 <= 1'b0;
    point_p2 <= 1'b0;
    if (rst) begin
      st       <= SERVE;
      bx       <= 10'(CX);
      by       <= 10'(CY);
      dx       <= 1'b1;
      dy       <= 1'b1;
      serve_dy <= 1'b1;
      cnt      <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      case (st)
        SERVE: begin
          bx <= 10'(CX);
          by <= 10'(CY);
          if (frame_tick) begin
            if (cnt == CW'(SERVE_FRAMES - 1)) begin
              st       <= PLAY;
              cnt      <= '0;
              dy       <= serve_dy;
              serve_dy <= ~serve_dy;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        PLAY: begin
          if (frame_tick) begin
            if (wall_t) begin
              by <= '0;
              dy <= 1'b1;
            end else if (wall_b) begin
              by <= 10'(V_RES - BALL_SIZE);
              dy <= 1'b0;
            end else begin
              by <= ny[9:0];
            end
            // The next serve heads toward whoever just conceded.
            if (hit_l) begin
              bx <= 10'(LF);
              dx <= 1'b1;
            end else if (hit_r) begin
              bx <= 10'(RF - BALL_SIZE);
              dx <= 1'b0;
            end else if (miss_l) begin
              bx       <= '0;
              s2       <= s2 + 1'b1;
              point_p2 <= 1'b1;
              dx       <= 1'b0;
              st       <= POINT;
              cnt      <= '0;
            end else if (miss_r) begin
              bx       <= 10'(H_RES - BALL_SIZE);
              s1       <= s1 + 1'b1;
              point_p1 <= 1'b1;
              dx       <= 1'b1;
              st       <= POINT;
              cnt      <= '0;
            end else begin
              bx <= nx[9:0];
            end
          end
        end
        POINT: begin
          if (frame_tick) begin
            if (cnt == CW'(HOLD - 1)) begin
              cnt <= '0;
              if (s1 == 4'(SCORE_MAX) || s2 == 4'(SCORE_MAX)) begin
                st <= GAMEOVER;
              end else begin
                st <= SERVE;
                bx <= 10'(CX);
                by <= 10'(CY);
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        GAMEOVER: begin
          if (start) begin
            st       <= SERVE;
            bx       <= 10'(CX);
            by       <= 10'(CY);
            dx       <= 1'b1;
            dy       <= 1'b1;
            serve_dy <= 1'b1;
            cnt      <= '0;
            s1       <= '0;
            s2       <= '0;
          end
        end
        default: st <= SERVE;
      endcase
    end
  end

  assign ball      = {bx, by};
  assign score     = {s1, s2};
  assign state     = st;
  assign game_over = (st == GAMEOVER);
endmodule

// File: tb/tb_pong_core.sv
// Directed bench for pong_core: an integer game model checked against the DUT every
// cycle, plus hand-computed checkpoints along one scripted rally and a full match.
module tb_pong_core;
  localparam int H_RES = 640, V_RES = 480, BS = 8, PH = 64;
  localparam int LF = 24, RF = 616, SPEED = 4, SERVE_FRAMES = 60, SCORE_MAX = 9;
  localparam int CX = 316, CY = 236;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [19:0] ppos = '0;
  logic [19:0] ball;
  logic [7:0]  score;
  logic [1:0]  state;
  logic        point_p1, point_p2, game_over;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int p1_mode = 1;   // 0: paddle tracks the ball, 1: paddle parked off-screen
  int p2_mode = 1;

  // Model state: phase 0 SERVE, 1 PLAY, 2 POINT, 3 GAMEOVER.
  int m_phase, m_bx, m_by, m_vx, m_vy, m_cnt, m_s1, m_s2;
  bit m_serve_up, m_p1, m_p2;

  pong_core dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .ppos(ppos),
    .ball(ball), .score(score), .state(state),
    .point_p1(point_p1), .point_p2(point_p2), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_center();
    m_bx = CX;
    m_by = CY;
    m_cnt = 0;
  endtask

  always @(posedge clk) begin
    int nx, ny, oy;
    bit ov1, ov2;
    m_p1 = 1'b0;
    m_p2 = 1'b0;
    if (rst) begin
      m_phase = 0; model_center(); m_s1 = 0; m_s2 = 0;
      m_vx = SPEED; m_vy = SPEED; m_serve_up = 1'b0;
    end else if (m_phase == 3) begin
      if (start) begin
        m_phase = 0; model_center(); m_s1 = 0; m_s2 = 0;
        m_vx = SPEED; m_vy = SPEED; m_serve_up = 1'b0;
      end
    end else if (frame_tick) begin
      if (m_phase == 0) begin
        m_cnt++;
        if (m_cnt == SERVE_FRAMES) begin
          m_phase = 1;
          m_cnt = 0;
          m_vy = m_serve_up ? -SPEED : SPEED;
          m_serve_up = !m_serve_up;
        end
      end else if (m_phase == 2) begin
        m_cnt++;
        if (m_cnt == SERVE_FRAMES / 2) begin
          if (m_s1 == SCORE_MAX || m_s2 == SCORE_MAX) begin
            m_phase = 3;
            m_cnt = 0;
          end else begin
            m_phase = 0;
            model_center();
          end
        end
      end else begin
        nx = m_bx + m_vx;
        ny = m_by + m_vy;
        oy = m_by;
        ov1 = (oy + BS > int'(ppos[9:0])) && (oy < int'(ppos[9:0]) + PH);
        ov2 = (oy + BS > int'(ppos[19:10])) && (oy < int'(ppos[19:10]) + PH);
        if (ny <= 0) begin m_by = 0; m_vy = SPEED; end
        else if (ny >= V_RES - BS) begin m_by = V_RES - BS; m_vy = -SPEED; end
        else m_by = ny;
        if (m_vx < 0 && m_bx >= LF && nx <= LF && ov1) begin
          m_bx = LF; m_vx = SPEED;
        end else if (m_vx > 0 && m_bx + BS <= RF && nx + BS >= RF && ov2) begin
          m_bx = RF - BS; m_vx = -SPEED;
        end else if (nx <= 0) begin
          m_bx = 0; m_s2++; m_p2 = 1'b1; m_vx = -SPEED; m_phase = 2; m_cnt = 0;
        end else if (nx >= H_RES - BS) begin
          m_bx = H_RES - BS; m_s1++; m_p1 = 1'b1; m_vx = SPEED; m_phase = 2; m_cnt = 0;
        end else begin
          m_bx = nx;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ball", 32'(ball), 32'({m_bx[9:0], m_by[9:0]}));
      check("score", 32'(score), 32'({m_s1[3:0], m_s2[3:0]}));
      check("state", 32'(state), 32'(m_phase[1:0]));
      check("pulses", 32'({point_p1, point_p2, game_over}), 32'({m_p1, m_p2, m_phase == 3}));
    end
  end

  task automatic set_paddles();
    int p1, p2, trk;
    trk = (m_by >= 16) ? m_by - 16 : 0;
    p1 = (p1_mode == 0) ? trk : 900;
    p2 = (p2_mode == 0) ? trk : 900;
    ppos = {p2[9:0], p1[9:0]};
  endtask

  // Each frame is one tick cycle followed by one idle cycle.
  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      set_paddles();
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int budget;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ball", 32'(ball), 32'({10'd316, 10'd236}));
    check("rst_score", 32'(score), 32'h00);
    check("rst_state", 32'(state), 32'd0);

    // First serve: P2 returns, P1 parked.
    p1_mode = 1; p2_mode = 0;
    do_tick(60);
    check("launch_state", 32'(state), 32'd1);
    check("launch_ball", 32'(ball), 32'({10'd316, 10'd236}));
    do_tick(1);
    check("first_move", 32'(ball), 32'({10'd320, 10'd240}));
    do_tick(58);
    check("bottom_wall", 32'(ball), 32'({10'd552, 10'd472}));
    do_tick(14);
    check("p2_hit", 32'(ball), 32'({10'd608, 10'd416}));
    check("p2_hit_score", 32'(score), 32'h00);

    p1_mode = 0; p2_mode = 1;
    do_tick(1);
    check("p2_reverse", 32'(ball), 32'({10'd604, 10'd412}));
    start = 1'b1;
    do_tick(103);
    start = 1'b0;
    check("top_wall", 32'(ball), 32'({10'd192, 10'd0}));
    do_tick(42);
    check("p1_hit", 32'(ball), 32'({10'd24, 10'd168}));

    // P2 parked: ball runs off the right edge.
    p1_mode = 1;
    do_tick(151);
    set_paddles();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("p1_point_pulse", 32'(point_p1), 32'd1);
    check("p1_point_ball", 32'(ball), 32'({10'd632, 10'd168}));
    check("p1_point_score", 32'(score), 32'h10);
    check("p1_point_state", 32'(state), 32'd2);
    @(negedge clk);
    check("p1_pulse_once", 32'(point_p1), 32'd0);
    do_tick(29);
    check("point_hold", 32'(state), 32'd2);
    do_tick(1);
    check("reserve_state", 32'(state), 32'd0);
    check("reserve_ball", 32'(ball), 32'({10'd316, 10'd236}));

    // Play the match out: P1 tracks, P2 parked.
    p1_mode = 0; p2_mode = 1;
    budget = 4000;
    while (m_phase != 3 && budget > 0) begin
      do_tick(1);
      budget--;
    end
    check("gameover_state", 32'(state), 32'd3);
    check("gameover_score", 32'(score), 32'h90);
    check("gameover_flag", 32'(game_over), 32'd1);
    do_tick(5);
    check("gameover_frozen", 32'(score), 32'h90);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_state", 32'(state), 32'd0);
    check("restart_score", 32'(score), 32'h00);
    check("restart_flag", 32'(game_over), 32'd0);

    do_tick(85);
    check("replay_ball", 32'(ball), 32'({10'd416, 10'd336}));
    rst = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frame_tick = 1'b0;
    check("midplay_rst_ball", 32'(ball), 32'({10'd316, 10'd236}));
    check("midplay_rst_score", 32'(score), 32'h00);
    check("midplay_rst_state", 32'(state), 32'd0);
    do_tick(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pong_core.md
PONG_CORE -- requirements
Module: pong_core

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_RES 640 visible width px; V_RES 480 visible height px; BALL_SIZE 8 ball side px; PADDLE_H 64 paddle height px; PADDLE_W 8 paddle width px; PADDLE_X 16 left paddle x offset px; SPEED 4 px moved per frame per axis; SERVE_FRAMES 60 frames held before launch; SCORE_MAX 9 winning score (1..15).
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1: single clock (pixel clock domain).
- rst in 1: synchronous, active-high reset.
- frame_tick in 1: one-cycle pulse once per frame.
- start in 1: level; restarts the match from GAMEOVER.
- ppos in 20: {p2pos, p1pos}; each is the paddle top y.
- ball out 20: {ball_x, ball_y}; top-left corner, 10 bits each.
- score out 8: {p1 score[7:4], p2 score[3:0]}, binary.
- state out 2: 0 SERVE, 1 PLAY, 2 POINT, 3 GAMEOVER.
- point_p1, point_p2 out 1: one-cycle pulse when that player scores.
- game_over out 1: high while in GAMEOVER.

Function
REQ-003 All state SHALL update only on the rising edge of clk; ball motion and frame counting SHALL advance only in cycles where frame_tick=1.
REQ-004 Derived constants: CX=(H_RES-BALL_SIZE)/2, CY=(V_RES-BALL_SIZE)/2, LF=PADDLE_X+PADDLE_W, RF=H_RES-PADDLE_X-PADDLE_W.
REQ-005 Position arithmetic SHALL use 11-bit signed intermediates; no 10-bit wrap-around SHALL ever be visible on ball.
REQ-006 SERVE: ball held at (CX,CY); frame counter increments per tick; on the tick where the count reaches SERVE_FRAMES, go to PLAY with the counter cleared and the ball unmoved.
REQ-007 Serve direction: dx toward the player who conceded the last point, toward P2 (+x) after reset or restart; dy SHALL alternate every serve, starting +y.
REQ-008 PLAY, per tick: nx=x±SPEED, ny=y±SPEED; X and Y rules are evaluated independently, so both may apply in the same tick.
REQ-009 Top wall: ny<=0 -> y=0, dy=+. Bottom wall: ny>=V_RES-BALL_SIZE -> y=V_RES-BALL_SIZE, dy=-.
REQ-010 Left paddle hit: dx=-, x>=LF, nx<=LF, and y+BALL_SIZE>p1pos and y<p1pos+PADDLE_H -> x=LF, dx=+.
REQ-011 Right paddle hit: dx=+, x+BALL_SIZE<=RF, nx+BALL_SIZE>=RF, and the same overlap test against p2pos -> x=RF-BALL_SIZE, dx=-.
REQ-012 Miss: with no paddle hit, nx<=0 scores for P2; nx>=H_RES-BALL_SIZE scores for P1; the ball is clamped to that edge.
REQ-013 On a score, the same edge SHALL increment the scorer's nibble, pulse its point_pX for exactly one cycle, and enter POINT.
REQ-014 POINT: ball frozen for SERVE_FRAMES/2 ticks, then enter SERVE with the ball recentred. If the updated score equals SCORE_MAX, enter GAMEOVER instead.
REQ-015 GAMEOVER: ball and score frozen, frame_tick ignored, game_over=1. start=1 clears score, resets direction per REQ-007 and enters SERVE on the next edge.
REQ-016 start SHALL be ignored outside GAMEOVER. ppos values are sampled combinationally at each tick; out-of-range ppos SHALL simply produce no overlap.

Reset
REQ-017 rst=1 SHALL, on the next edge and regardless of state, set state=SERVE, ball={CX,CY}, score=0, counters=0, point pulses=0, game_over=0, dx=+, dy=+.
REQ-018 Reset asserted mid-frame or mid-POINT SHALL discard any pending score or motion.

Verification (defaults)
REQ-019 Reset then 60 ticks -> ball={316,236}, state=PLAY; next tick -> ball={320,240}.
REQ-020 P2 paddle away (p2pos=0) with the ball travelling right near y=240 -> ball_x clamps at 632, point_p1 pulses once, score=8'h10, state=POINT; after 30 more ticks -> SERVE with ball {316,236}.
REQ-021 p2pos=ball_y-16 on approach -> ball_x=608, dx reverses, no score change.
REQ-022 Ball at y=2 moving up -> y=0 next tick, dy=+; a corner paddle-plus-wall tick applies both reflections.
REQ-023 Score 8'h80 and P1 scores -> score=8'h90, game_over=1, ticks ignored; start=1 -> score=0, state=SERVE.
REQ-024 rst pulsed during PLAY at {400,100} -> next cycle ball={316,236}, score=0, state=SERVE.
